mem_bank_port_ctrl: RTL and testbench

Request/response front-end for one port of the dual-port memory bank. Converts a valid/ready master interface (fetch unit, LSU or DMA) into the bank's en/we/addr/din port signals. Reads have fixed 1-cycle RAM latency, and the bank's output mux selects on the live address, so this block holds the address stable during read return and inserts a bubble on bank switches. Read data is buffered in a response FIFO so the master can backpressure.

---
 rtl/mem_bank_pkg.sv | 17 +
 rtl/mem_rsp_fifo.sv | 67 ++++++
 rtl/mem_bank_port_ctrl.sv | 129 ++++++++++++
 tb/tb_mem_bank_port_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bank_pkg.sv
// Shared constants and geometry helpers for the memory bank and its
// port controllers.
package mem_bank_pkg;

   localparam int BramAddrWidth = 10;
   localparam int BramColWidth  = 8;
   localparam int BramNumCol    = 4;

   function automatic int num_banks(input int size_kib, input int data_width);
      return (size_kib * 1024) / ((data_width / 8) * 1024);
   endfunction

   function automatic int addr_width(input int size_kib, input int data_width);
      return $clog2((size_kib * 1024) / (data_width / 8));
   endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// Response FIFO with a registered head word, so the read data seen by
// the master is a flop output and holds steady under backpressure.
module mem_rsp_fifo
   import mem_bank_pkg::*;
#(
   parameter int  DataWidth = 128,
   parameter int  RspDepth  = 4,
   localparam int PtrW      = $clog2(RspDepth),
   localparam int CntW      = PtrW + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 push_i,
   input  logic [DataWidth-1:0] wdata_i,
   input  logic                 pop_i,
   output logic [DataWidth-1:0] rdata_o,
   output logic [CntW-1:0]      count_o,
   output logic                 full_o,
   output logic                 empty_o
);

   logic [DataWidth-1:0] mem_q [RspDepth];
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [DataWidth-1:0] head_q, head_d;
   logic                 do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CntW'(RspDepth));
   assign count_o = cnt_q;
   assign rdata_o = head_q;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PtrW'(push_i);
      rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
      cnt_d    = cnt_q + CntW'(push_i) - CntW'(do_pop);
      head_d   = head_q;
      // A word pushed into the slot that becomes head this cycle is bypassed
      if (cnt_d != '0) begin
         if (push_i && (wr_ptr_q == rd_ptr_d)) head_d = wdata_i;
         else                                   head_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         head_q   <= head_d;
      end
   end

   assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));

endmodule

// File: rtl/mem_bank_port_ctrl.sv
// valid/ready front-end for one memory bank port with credit-based response FIFO.
// Define MEM_PORT_CTRL_WR_ACK_EN to make writes return a zero response entry.
module mem_bank_port_ctrl
   import mem_bank_pkg::*;
#(
   parameter int  SizeKiB   = 64,
   parameter int  DataWidth = 128,
   parameter int  RspDepth  = 4,
   localparam int NumCol    = DataWidth / 8,
   localparam int AddrWidth = addr_width(SizeKiB, DataWidth),
   localparam int NumBanks  = num_banks(SizeKiB, DataWidth)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [NumCol-1:0]    req_we_i,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic [DataWidth-1:0] req_wdata_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [DataWidth-1:0] rsp_rdata_o,
   output logic                 mem_en_o,
   output logic [NumCol-1:0]    mem_we_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic [DataWidth-1:0] mem_wdata_o,
   input  logic [DataWidth-1:0] mem_rdata_i
);

`ifdef MEM_PORT_CTRL_WR_ACK_EN
   localparam bit WrAck = 1'b1;
`else
   localparam bit WrAck = 1'b0;
`endif

   localparam int CntW = $clog2(RspDepth) + 1;
   localparam int UW   = CntW + 1;

   logic                 mem_en_q, mem_en_d;
   logic [NumCol-1:0]    mem_we_q, mem_we_d;
   logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
   logic [DataWidth-1:0] mem_wdata_q, mem_wdata_d;
   logic                 iss_rsp_q, iss_rsp_d;
   logic                 iss_rd_q, iss_rd_d;
   logic                 dat_rsp_q, dat_rd_q;

   logic                 req_rd, accept, bank_hz, credit_ok;
   logic [CntW-1:0]      fifo_cnt;
   logic                 fifo_full, fifo_empty;
   logic [UW-1:0]        used;

   assign req_rd = (req_we_i == '0);

   // Entries already queued plus those still travelling to the FIFO
   assign used = UW'(fifo_cnt) + UW'(iss_rsp_q) + UW'(dat_rsp_q);
   assign credit_ok = !fifo_full && (used < UW'(RspDepth));

   // The bank output mux follows the live address, so a bank switch must
   // wait until the read in issue has had its data cycle.
   if (NumBanks > 1) begin : g_bank
      assign bank_hz = iss_rsp_q &&
         (req_addr_i[AddrWidth-1:BramAddrWidth] !=
          mem_addr_q[AddrWidth-1:BramAddrWidth]);
   end else begin : g_nobank
      assign bank_hz = 1'b0;
   end

   assign req_ready_o = rst_ni && credit_ok && !bank_hz;
   assign accept      = req_valid_i && req_ready_o;

   always_comb begin
      mem_en_d    = accept;
      mem_we_d    = '0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      iss_rd_d    = accept && req_rd;
      iss_rsp_d   = accept && (WrAck || req_rd);
      if (accept) begin
         mem_we_d    = req_we_i;
         mem_addr_d  = req_addr_i;
         mem_wdata_d = req_wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_en_q    <= 1'b0;
         mem_we_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         iss_rsp_q   <= 1'b0;
         iss_rd_q    <= 1'b0;
         dat_rsp_q   <= 1'b0;
         dat_rd_q    <= 1'b0;
      end else begin
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         iss_rsp_q   <= iss_rsp_d;
         iss_rd_q    <= iss_rd_d;
         dat_rsp_q   <= iss_rsp_q;
         dat_rd_q    <= iss_rd_q;
      end
   end

   assign mem_en_o    = mem_en_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

   mem_rsp_fifo #(
      .DataWidth(DataWidth),
      .RspDepth (RspDepth)
   ) u_rsp_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push_i (dat_rsp_q),
      .wdata_i(dat_rd_q ? mem_rdata_i : '0),
      .pop_i  (rsp_ready_i),
      .rdata_o(rsp_rdata_o),
      .count_o(fifo_cnt),
      .full_o (fifo_full),
      .empty_o(fifo_empty)
   );

   assign rsp_valid_o = !fifo_empty;

endmodule

// File: tb/tb_mem_bank_port_ctrl.sv
// Directed bench for mem_bank_port_ctrl with a banked 1-cycle RAM model
// whose output mux follows the live port address.
module tb_mem_bank_port_ctrl;

   localparam int DW = 128;
   localparam int NC = 16;
   localparam int AW = 12;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b1;
   logic          req_valid_i = 1'b0;
   logic          req_ready_o;
   logic [NC-1:0] req_we_i = '0;
   logic [AW-1:0] req_addr_i = '0;
   logic [DW-1:0] req_wdata_i = '0;
   logic          rsp_valid_o;
   logic          rsp_ready_i = 1'b0;
   logic [DW-1:0] rsp_rdata_o;
   logic          mem_en_o;
   logic [NC-1:0] mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i;

   always #5 clk_i = ~clk_i;

   mem_bank_port_ctrl #(
      .SizeKiB  (64),
      .DataWidth(DW),
      .RspDepth (4)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .req_valid_i(req_valid_i),
      .req_ready_o(req_ready_o),
      .req_we_i   (req_we_i),
      .req_addr_i (req_addr_i),
      .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_ready_i(rsp_ready_i),
      .rsp_rdata_o(rsp_rdata_o),
      .mem_en_o   (mem_en_o),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i)
   );

   // Four 1024-word banks, each with its own output register
   logic [DW-1:0] ram [1 << AW];
   logic [DW-1:0] dout_q [4];

   always @(posedge clk_i) begin
      if (mem_en_o) begin
         for (int b = 0; b < NC; b++)
            if (mem_we_o[b]) ram[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
         dout_q[mem_addr_o[11:10]] <= ram[mem_addr_o];
      end
   end

   assign mem_rdata_i = dout_q[mem_addr_o[11:10]];

   int n_run = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [DW-1:0] obs,
                        input logic [DW-1:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   logic [DW-1:0] rsp_q [$];
   int            rsp_cyc [$];

   always @(negedge clk_i) begin
      if (rst_ni && rsp_valid_o && rsp_ready_i) begin
         rsp_q.push_back(rsp_rdata_o);
         rsp_cyc.push_back(cyc);
      end
   end

   // Bank select must not move during the data cycle of a read
   logic          prev_rd = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   int            addr_viol = 0;

   always @(negedge clk_i) begin
      if (rst_ni && prev_rd && (mem_addr_o[11:10] != prev_addr[11:10]))
         addr_viol++;
      prev_rd   = rst_ni && mem_en_o && (mem_we_o == '0);
      prev_addr = mem_addr_o;
   end

   function automatic logic [DW-1:0] pat(input int a);
      logic [15:0] h;
      h = 16'(a + 'h1000);
      return {8{h}};
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [NC-1:0] we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid_i = v;
      req_we_i    = we;
      req_addr_i  = a;
      req_wdata_i = d;
   endtask

   task automatic issue(input logic [NC-1:0] we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int stalls);
      stalls = 0;
      drive(1'b1, we, a, d);
      @(negedge clk_i);
      while (!req_ready_o && stalls < 20) begin
         stalls++;
         step();
         @(negedge clk_i);
      end
      step();
      drive(1'b0, '0, a, '0);
   endtask

   localparam logic [DW-1:0] A5 = {16{8'hA5}};

   initial begin
      int st;
      int stall_sum;
      int acc;
      logic [AW-1:0] a;
      logic [AW-1:0] alt_addr [4];
      int alt_stall [4];

      for (int i = 0; i < (1 << AW); i++) ram[i] = pat(i);
      for (int i = 0; i < 4; i++) dout_q[i] = '0;
      ram[5]    = A5;
      ram['h10] = {16{8'hCC}};

      #2 rst_ni = 1'b0;
      repeat (2) @(negedge clk_i);
      check("rst_ready", req_ready_o, 0);
      check("rst_en", mem_en_o, 0);
      check("rst_we", mem_we_o, 0);
      check("rst_addr", mem_addr_o, 0);
      check("rst_wdata", mem_wdata_o, 0);
      check("rst_rvalid", rsp_valid_o, 0);
      check("rst_rdata", rsp_rdata_o, 0);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      rsp_ready_i = 1'b1;
      step();

      // single read with exact stage timing
      rsp_q.delete();
      drive(1'b1, '0, 12'h005, '0);
      @(negedge clk_i);
      check("t1_ready", req_ready_o, 1);
      step();
      drive(1'b0, '0, 12'h005, '0);
      @(negedge clk_i);
      check("t1_issue_en", mem_en_o, 1);
      check("t1_issue_addr", mem_addr_o, 12'h005);
      step();
      @(negedge clk_i);
      check("t1_data_en", mem_en_o, 0);
      check("t1_data_rvalid", rsp_valid_o, 0);
      step();
      @(negedge clk_i);
      check("t1_rsp_valid", rsp_valid_o, 1);
      check("t1_rsp_data", rsp_rdata_o, A5);
      step();
      @(negedge clk_i);
      check("t1_popped", rsp_valid_o, 0);
      step();

      // partial write then read-back; write gives no response
      rsp_q.delete();
      issue(16'h000F, 12'h010, 128'h1234_5678, st);
      check("t2_wr_stall", st, 0);
      issue('0, 12'h010, '0, st);
      repeat (6) step();
      check("t2_rsp_cnt", rsp_q.size(), 1);
      if (rsp_q.size() == 1)
         check("t2_rdata", rsp_q[0], {{12{8'hCC}}, 32'h1234_5678});

      // back-to-back reads
      rsp_q.delete();
      rsp_cyc.delete();
      stall_sum = 0;
      for (int i = 0; i < 8; i++) begin
         issue('0, AW'(i), '0, st);
         stall_sum += st;
      end
      repeat (6) step();
      check("t3_stalls", stall_sum, 0);
      check("t3_rsp_cnt", rsp_q.size(), 8);
      if (rsp_q.size() == 8) begin
         for (int i = 0; i < 8; i++)
            check($sformatf("t3_rdata%0d", i), rsp_q[i], (i == 5) ? A5 : pat(i));
         check("t3_consecutive", rsp_cyc[7] - rsp_cyc[0], 7);
      end

      // alternating banks
      rsp_q.delete();
      addr_viol = 0;
      alt_addr[0] = 12'h001;
      alt_addr[1] = 12'h401;
      alt_addr[2] = 12'h002;
      alt_addr[3] = 12'h402;
      for (int i = 0; i < 4; i++) issue('0, alt_addr[i], '0, alt_stall[i]);
      repeat (6) step();
      for (int i = 0; i < 4; i++)
         check($sformatf("t4_stall%0d", i), alt_stall[i], (i == 0) ? 0 : 1);
      check("t4_rsp_cnt", rsp_q.size(), 4);
      if (rsp_q.size() == 4)
         for (int i = 0; i < 4; i++)
            check($sformatf("t4_rdata%0d", i), rsp_q[i], pat(int'(alt_addr[i])));
      check("t4_addr_hold", addr_viol, 0);

      // credit limit under backpressure
      rsp_ready_i = 1'b0;
      rsp_q.delete();
      acc = 0;
      a = 12'h030;
      drive(1'b1, '0, a, '0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_i);
         if (req_ready_o) begin
            acc++;
            step();
            a++;
            drive(1'b1, '0, a, '0);
         end else begin
            step();
         end
      end
      check("t5_accepted", acc, 4);
      @(negedge clk_i);
      check("t5_ready_low", req_ready_o, 0);
      check("t5_head_stable", rsp_rdata_o, pat('h30));
      step();
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      step();
      rsp_ready_i = 1'b0;
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_i);
         if (req_ready_o) begin
            acc++;
            step();
            a++;
            drive(1'b1, '0, a, '0);
         end else begin
            step();
         end
      end
      drive(1'b0, '0, a, '0);
      check("t5_one_more", acc, 1);
      check("t5_popped", rsp_q.size(), 1);
      if (rsp_q.size() == 1) check("t5_pop_data", rsp_q[0], pat('h30));

      // reset with reads in flight and FIFO occupied
      rsp_ready_i = 1'b1;
      repeat (8) step();
      rsp_ready_i = 1'b0;
      rsp_q.delete();
      for (int i = 0; i < 3; i++) issue('0, AW'('h40 + i), '0, st);
      rst_ni = 1'b0;
      #1;
      check("t6_ready", req_ready_o, 0);
      check("t6_en", mem_en_o, 0);
      check("t6_we", mem_we_o, 0);
      check("t6_addr", mem_addr_o, 0);
      check("t6_wdata", mem_wdata_o, 0);
      check("t6_rvalid", rsp_valid_o, 0);
      check("t6_rdata", rsp_rdata_o, 0);
      repeat (2) step();
      rst_ni = 1'b1;
      rsp_ready_i = 1'b1;
      repeat (6) step();
      check("t6_no_rsp", rsp_q.size(), 0);
      check("t6_rvalid_idle", rsp_valid_o, 0);
      issue('0, 12'h005, '0, st);
      repeat (5) step();
      check("t6_new_cnt", rsp_q.size(), 1);
      if (rsp_q.size() == 1) check("t6_new_data", rsp_q[0], A5);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
